clock_rate_meter: RTL and testbench

- Measures an incoming slow square wave, normally one of the divided clocks (2 Hz, 1 Hz, 0.5 Hz, 0.25 Hz) produced by the clock-divider block, in CLOCK_50 cycles.
- Classifies the measurement into one of those rates and reports lock or loss of clock.
- Sits on the receiving end of the divider outputs. Used for self-check and for selecting FSM timing.

---
 rtl/clock_rate_meter_if.sv | 22 ++
 rtl/clock_rate_meter.sv | 194 +++++++++++++++++++
 tb/tb_clock_rate_meter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_rate_meter_if.sv
// Measurement bundle: the slow clock under test plus the meter's period/rate/lock reports.
// master = meter side (consumes clk_in, drives reports); slave = the block that feeds and reads it.
interface clock_rate_meter_if #(
    parameter int CNT_W = 28
);
    logic             clk_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [2:0]       rate_code;
    logic             locked;
    logic             no_clk;

    modport master (
        input  clk_in,
        output period, period_valid, rate_code, locked, no_clk
    );

    modport slave (
        output clk_in,
        input  period, period_valid, rate_code, locked, no_clk
    );
endinterface

// File: rtl/clock_rate_meter.sv
// Measures a slow square wave in CLOCK_50 cycles, classifies it (2/1/0.5/0.25 Hz) and flags lock / loss of clock.
// Reports are registered on the edge ending the rise cycle; no backpressure. CLOCK_RATE_METER_GLITCH_FILTER_EN adds a FILT_LEN input filter.
module clock_rate_meter #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TOL      = 1000,
    parameter int TIMEOUT  = 250_000_000,
    parameter int CNT_W    = 28
`ifdef CLOCK_RATE_METER_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN = 16
`endif
) (
    input logic                CLOCK_50,
    input logic                reset,
    clock_rate_meter_if.master mtr
);

    typedef enum logic [1:0] {S_WAIT, S_MEAS, S_LOCK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   P2      = (CNT_W+1)'(CLK_FREQ / 2);
    localparam logic [CNT_W:0]   P1      = (CNT_W+1)'(CLK_FREQ);
    localparam logic [CNT_W:0]   P05     = (CNT_W+1)'(2 * CLK_FREQ);
    localparam logic [CNT_W:0]   P025    = (CNT_W+1)'(4 * CLK_FREQ);
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);

    logic             sync1, sync2, sync3;
    logic             lvl;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   meas;
    logic [2:0]       new_code;
    logic             timeout;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             vld_q, vld_d;
    logic [2:0]       code_q, code_d;
    logic             locked_q, locked_d;
    logic             no_clk_q, no_clk_d;

    // sync3 holds the previous level seen by the edge detector
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= mtr.clk_in;
            sync2 <= sync1;
            sync3 <= lvl;
        end
    end

`ifdef CLOCK_RATE_METER_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic          filt_lvl;
    logic [FW-1:0] filt_cnt;

    // filtered level follows sync2 only after FILT_LEN consecutive differing cycles
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            filt_lvl <= 1'b0;
            filt_cnt <= '0;
        end else if (sync2 == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            filt_lvl <= sync2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync2;
`endif

    assign rise = lvl & ~sync3;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (rise)
            cnt <= '0;
        else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
    end

    // one extra bit so the distance to each nominal never underflows
    assign meas = {1'b0, cnt} + (CNT_W+1)'(1);

    function automatic logic near(input logic [CNT_W:0] m, input logic [CNT_W:0] nom);
        logic [CNT_W:0] diff;
        diff = (m >= nom) ? (m - nom) : (nom - m);
        return diff <= TOL_W;
    endfunction

    always_comb begin
        if (near(meas, P2))
            new_code = 3'd1;
        else if (near(meas, P1))
            new_code = 3'd2;
        else if (near(meas, P05))
            new_code = 3'd3;
        else if (near(meas, P025))
            new_code = 3'd4;
        else
            new_code = 3'd7;
    end

    assign timeout = (state_q != S_WAIT) && (cnt == CNT_MAX) && !rise;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q  <= S_WAIT;
            period_q <= '0;
            vld_q    <= 1'b0;
            code_q   <= 3'd0;
            locked_q <= 1'b0;
            no_clk_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            code_q   <= code_d;
            locked_q <= locked_d;
            no_clk_q <= no_clk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (rise)
                    state_d = S_MEAS;
            end
            S_MEAS: begin
                if (rise) begin
                    if (new_code != 3'd7 && new_code == code_q)
                        state_d = S_LOCK;
                end else if (timeout) begin
                    state_d = S_WAIT;
                end
            end
            S_LOCK: begin
                if (rise) begin
                    if (new_code != code_q)
                        state_d = S_MEAS;
                end else if (timeout) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        period_d = period_q;
        vld_d    = 1'b0;
        code_d   = code_q;
        locked_d = locked_q;
        no_clk_d = no_clk_q;
        case (state_q)
            S_WAIT: begin
                locked_d = 1'b0;
                if (rise)
                    no_clk_d = 1'b0;
            end
            default: begin
                if (rise) begin
                    vld_d    = 1'b1;
                    period_d = meas[CNT_W-1:0];
                    code_d   = new_code;
                    locked_d = (state_d == S_LOCK);
                end else if (timeout) begin
                    no_clk_d = 1'b1;
                    code_d   = 3'd0;
                    locked_d = 1'b0;
                end
            end
        endcase
    end

    assign mtr.period       = period_q;
    assign mtr.period_valid = vld_q;
    assign mtr.rate_code    = code_q;
    assign mtr.locked       = locked_q;
    assign mtr.no_clk       = no_clk_q;

endmodule

// File: tb/tb_clock_rate_meter.sv
// Randomized and directed bench for clock_rate_meter against a period-level reference model.
// Each generated rising edge is predicted as "arm" or "report(period, code, lock)".
module tb_clock_rate_meter;

    localparam int CLK_FREQ = 1000;
    localparam int TOL      = 10;
    localparam int TIMEOUT  = 5000;
    localparam int CNT_W    = 16;

    logic CLOCK_50;
    logic reset;

    clock_rate_meter_if #(.CNT_W(CNT_W)) bus ();

    clock_rate_meter #(
        .CLK_FREQ(CLK_FREQ),
        .TOL     (TOL),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
`ifdef CLOCK_RATE_METER_GLITCH_FILTER_EN
        ,
        .FILT_LEN(16)
`endif
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .mtr     (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;

    int obs_per_q[$];
    int obs_code_q[$];
    int obs_lock_q[$];

    bit armed     = 1'b0;
    int prev_code = 0;
    int last_per  = 0;

    always @(negedge CLOCK_50) begin
        if (bus.period_valid === 1'b1) begin
            obs_per_q.push_back(int'(bus.period));
            obs_code_q.push_back(int'(bus.rate_code));
            obs_lock_q.push_back(int'(bus.locked));
        end
    end

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK_50);
    endtask

    function automatic int ref_code(input int p);
        int noms[4];
        noms = '{CLK_FREQ / 2, CLK_FREQ, 2 * CLK_FREQ, 4 * CLK_FREQ};
        for (int i = 0; i < 4; i++)
            if (((p > noms[i]) ? (p - noms[i]) : (noms[i] - p)) <= TOL) return i + 1;
        return 7;
    endfunction

    task automatic clear_obs();
        obs_per_q.delete();
        obs_code_q.delete();
        obs_lock_q.delete();
    endtask

    // one rising edge of clk_in: high for hi cycles, then low for lo cycles (lo=0 leaves it high)
    task automatic pulse(input int hi, input int lo, input bit glitch);
        bit exp_rep;
        int exp_per, exp_code, exp_lock;
        exp_rep  = armed;
        exp_per  = last_per;
        exp_code = 0;
        exp_lock = 0;
        if (armed) begin
            exp_code  = ref_code(exp_per);
            exp_lock  = (exp_code != 7 && exp_code == prev_code) ? 1 : 0;
            prev_code = exp_code;
        end
        armed    = 1'b1;
        last_per = hi + lo;
        bus.clk_in = 1'b1;
        wait_cyc(hi);
        if (lo > 0) begin
            bus.clk_in = 1'b0;
            if (glitch && lo > 400) begin
                wait_cyc(300);
                bus.clk_in = 1'b1;
                wait_cyc(5);
                bus.clk_in = 1'b0;
                wait_cyc(lo - 305);
            end else begin
                wait_cyc(lo);
            end
        end
        if (exp_rep) begin
            chk_val("report_count", obs_per_q.size(), 1);
            if (obs_per_q.size() > 0) begin
                chk_val("period", obs_per_q[0], exp_per);
                chk_val("rate_code", obs_code_q[0], exp_code);
                chk_val("locked", obs_lock_q[0], exp_lock);
            end
        end else begin
            chk_val("arm_no_report", obs_per_q.size(), 0);
        end
        clear_obs();
    endtask

    task automatic run_per(input int p, input int n);
        for (int i = 0; i < n; i++) pulse(p / 2, p - p / 2, 1'b0);
    endtask

    // since = cycles already elapsed since the last generated rising edge
    task automatic expect_timeout(input int since, input int exp_period);
        wait_cyc(TIMEOUT - 50 - since);
        chk_val("no_clk_before_timeout", bus.no_clk, 0);
        wait_cyc(100);
        chk_val("no_clk_after_timeout", bus.no_clk, 1);
        chk_val("rate_code_after_timeout", bus.rate_code, 0);
        chk_val("locked_after_timeout", bus.locked, 0);
        chk_val("period_held", bus.period, exp_period);
        chk_val("timeout_no_report", obs_per_q.size(), 0);
        clear_obs();
        armed     = 1'b0;
        prev_code = 0;
    endtask

    initial begin
        int nom[4];
        int p;
        int idx;
        nom = '{500, 1000, 2000, 4000};

        bus.clk_in = 1'b0;
        reset      = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk_val("rst_period", bus.period, 0);
        chk_val("rst_valid", bus.period_valid, 0);
        chk_val("rst_rate_code", bus.rate_code, 0);
        chk_val("rst_locked", bus.locked, 0);
        chk_val("rst_no_clk", bus.no_clk, 0);
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(5);

        // lock on 2 Hz, move to 0.25 Hz, then back down to 1 Hz
        run_per(500, 4);
        run_per(4000, 3);
        run_per(990, 3);

        // unknown rate and tolerance edges
        run_per(700, 3);
        run_per(510, 2);
        run_per(511, 2);
        run_per(490, 2);
        run_per(489, 2);

        // a period of exactly TIMEOUT still reports instead of timing out
        run_per(1000, 1);
        run_per(5000, 1);
        run_per(1000, 1);
        chk_val("no_clk_at_timeout_edge", bus.no_clk, 0);

        // clk_in stuck low after a lock, then restart
        run_per(1000, 3);
        expect_timeout(1000, 1000);
        run_per(1000, 1);
        chk_val("no_clk_cleared", bus.no_clk, 0);
        run_per(1000, 2);

        // clk_in stuck high
        pulse(TIMEOUT - 50, 0, 1'b0);
        expect_timeout(TIMEOUT - 50, 1000);
        bus.clk_in = 1'b0;
        wait_cyc(40);
        chk_val("stuck_high_no_report", obs_per_q.size(), 0);

        // reset in the middle of a locked measurement
        run_per(1000, 3);
        wait_cyc(300);
        #2 reset = 1'b0;
        #1;
        chk_val("midrst_period", bus.period, 0);
        chk_val("midrst_rate_code", bus.rate_code, 0);
        chk_val("midrst_locked", bus.locked, 0);
        chk_val("midrst_no_clk", bus.no_clk, 0);
        wait_cyc(3);
        reset = 1'b1;
        clear_obs();
        armed     = 1'b0;
        prev_code = 0;
        run_per(1000, 3);

`ifdef CLOCK_RATE_METER_GLITCH_FILTER_EN
        for (int i = 0; i < 3; i++) pulse(1000, 1000, 1'b1);
`endif

        p = 1000;
        for (int i = 0; i < 12; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 0) begin
                idx = $urandom_range(0, 2);
                if ($urandom_range(0, 7) == 0) idx = 3;
                p = nom[idx] + $urandom_range(0, 2 * (TOL + 6)) - (TOL + 6);
            end
            pulse(p / 2, p - p / 2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
